branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Parametrised, pipelined successor of the core's combinational branch-taken decision.
- Accepts one branch/jump per cycle over a valid/ready handshake. Resolves taken/not-taken with correct signed and unsigned compares, and computes the target, link address and misalignment fault.
- Returns a registered result one cycle later over a second valid/ready handshake.
- Sits between the execute-stage operand read and the PC-update / writeback logic of the multi-cycle core.

Parameters:
- XLEN, 32, operand/PC width in bits (32 or 64).
- IALIGN, 32, instruction alignment in bits; 32 requires target[1:0]==0, 16 requires target[0]==0.
- BHT_ENTRIES, 64, power-of-two count of 2-bit counters (used only with BRANCH_BHT_EN).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_funct3  in  3  RISC-V branch funct3; ignored when in_is_jal or in_is_jalr is set
- in_is_branch  in  1  conditional branch
- in_is_jal  in  1  JAL
- in_is_jalr  in  1  JALR
- in_pc  in  XLEN  instruction PC
- in_rs1  in  XLEN  rs1 value
- in_rs2  in  XLEN  rs2 value
- in_imm  in  XLEN  sign-extended immediate
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_taken  out  1  redirect PC
- out_target  out  XLEN  redirect address
- out_link  out  XLEN  in_pc+4 (rd value for JAL/JALR)
- out_misaligned  out  1  taken with misaligned target
- out_illegal  out  1  in_is_branch with funct3 010 or 011
- pred_pc  in  XLEN  lookup PC (BRANCH_BHT_EN only)
- pred_taken  out  1  prediction for pred_pc (BRANCH_BHT_EN only)

Behaviour:
- Reset (async, rst_n low): out_valid=0, out_taken=0, out_target=0, out_link=0, out_misaligned=0, out_illegal=0. Any in-flight result is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept on in_valid && in_ready; out_valid=1 on the next edge.
  - Result holds stable while out_valid && !out_ready.
  - Back-to-back accepts at full rate when out_ready is held high; the result register is overwritten only on accept.
  - If out_valid && out_ready and no accept, out_valid=0 next edge.
- Latency: exactly 1 cycle accept->out_valid.
- Compare (by funct3 when in_is_branch):
  - 000 eq; 001 ne.
  - 100 signed lt; 101 signed ge.
  - 110 unsigned lt; 111 unsigned ge.
  - 010/011: not taken, out_illegal=1.
  - Signed compares use true two's-complement: $signed, or MSB-flip then unsigned compare.
- Jumps: in_is_jal or in_is_jalr -> taken=1.
- No type flag set: taken=0, illegal=0 (treated as bubble).
- Priority when several flags are set: jalr > jal > branch.
- Target:
  - branch/jal: in_pc+in_imm, modulo 2^XLEN.
  - jalr: (in_rs1+in_imm) with bit0 cleared.
  - Computed even when not taken.
- Link: in_pc+4, wraps modulo 2^XLEN.
- Misaligned: taken && (IALIGN==32 ? target[1:0]!=0 : target[0]!=0). When misaligned is set, out_taken is still 1; the consumer traps.

Optional Feature:
- Macro: BRANCH_BHT_EN.
- Defined:
  - Adds a BHT of BHT_ENTRIES 2-bit saturating counters, indexed by pc[log2(BHT_ENTRIES)+1:2].
  - Counters reset to 01 (weakly not-taken).
  - pred_taken = counter[pred_pc index][1], combinational read.
  - On each result handshake (out_valid && out_ready) for a conditional branch that is not illegal: counter increments if taken, decrements if not, saturating at 00/11. The write uses the registered PC.
  - Jumps, bubbles and illegal requests do not update.
  - A same-cycle read and write of the same entry returns the old value.
- Undefined: no BHT storage; pred_pc ignored; pred_taken tied 0.

Test Plan:
- BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> one cycle later taken=1, target=0x120, link=0x104. BLTU with same operands -> taken=0.
- BGE rs1=0x80000000, rs2=0x7FFFFFFF -> taken=0. BGEU with same operands -> taken=1. BEQ rs1=rs2=5 -> taken=1.
- JALR rs1=0x1001, imm=2 -> target=0x1002. IALIGN=32: misaligned=1, taken=1. IALIGN=16: misaligned=0.
- Backpressure: 3 requests back-to-back with out_ready low for 2 cycles -> in_ready=0 while stalled, first result held stable, all 3 results delivered in order with no loss. Assert rst_n mid-stall -> out_valid=0 immediately.
- funct3=010 branch -> illegal=1, taken=0. pc=0xFFFFFFFC, imm=8 BEQ taken -> target=0x4, link=0x0 (wrap).
- BRANCH_BHT_EN: 3 taken BEQs at pc=0x40 -> pred_taken(0x40) goes 0->1->1 and the counter saturates at 11. Then 2 not-taken -> counter reaches 01, pred_taken=0. A JAL at pc=0x40 leaves the counter unchanged.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Pipelined branch/jump resolver: taken decision, target, link and fault flags, one-cycle registered result.
// Optional BRANCH_BHT_EN adds a table of 2-bit saturating counters trained on resolved conditional branches.
module branch_resolve_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned IALIGN      = 32,
  parameter int unsigned BHT_ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_is_branch,
  input  logic            in_is_jal,
  input  logic            in_is_jalr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_link,
  output logic            out_misaligned,
  output logic            out_illegal,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken
);

  logic            r_valid;
  logic            r_taken;
  logic [XLEN-1:0] r_target;
  logic [XLEN-1:0] r_link;
  logic            r_misaligned;
  logic            r_illegal;

  logic            w_accept;
  logic            w_sel_jalr;
  logic            w_sel_jal;
  logic            w_sel_br;
  logic            w_cmp;
  logic            w_illegal;
  logic            w_taken;
  logic            w_misaligned;
  logic [XLEN-1:0] w_pc_sum;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_link;
  logic            w_unused_pred;

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Decode, compare and address generation; jalr outranks jal outranks branch.
  always_comb begin
    w_sel_jalr = in_is_jalr;
    w_sel_jal  = !in_is_jalr && in_is_jal;
    w_sel_br   = !in_is_jalr && !in_is_jal && in_is_branch;
    w_cmp      = 1'b0;
    case (in_funct3)
      3'b000:  w_cmp = (in_rs1 == in_rs2);
      3'b001:  w_cmp = (in_rs1 != in_rs2);
      3'b100:  w_cmp = ($signed(in_rs1) <  $signed(in_rs2));
      3'b101:  w_cmp = ($signed(in_rs1) >= $signed(in_rs2));
      3'b110:  w_cmp = (in_rs1 <  in_rs2);
      3'b111:  w_cmp = (in_rs1 >= in_rs2);
      default: w_cmp = 1'b0;
    endcase
    w_illegal  = w_sel_br && (in_funct3[2:1] == 2'b01);
    w_taken    = w_sel_jalr || w_sel_jal || (w_sel_br && w_cmp && !w_illegal);
    w_pc_sum   = in_pc + in_imm;
    w_jalr_sum = in_rs1 + in_imm;
    w_target   = w_sel_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : w_pc_sum;
    w_link     = in_pc + XLEN'(4);
  end

  generate
    if (IALIGN == 32) begin : g_align32
      assign w_misaligned = w_taken && (w_target[1:0] != 2'b00);
    end else begin : g_align16
      assign w_misaligned = w_taken && w_target[0];
    end
  endgenerate

  // Result register: loads only on accept, drains when the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_taken      <= 1'b0;
      r_target     <= '0;
      r_link       <= '0;
      r_misaligned <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (w_accept) begin
      r_valid      <= 1'b1;
      r_taken      <= w_taken;
      r_target     <= w_target;
      r_link       <= w_link;
      r_misaligned <= w_misaligned;
      r_illegal    <= w_illegal;
    end else if (out_ready) begin
      r_valid      <= 1'b0;
    end
  end

  assign out_valid      = r_valid;
  assign out_taken      = r_taken;
  assign out_target     = r_target;
  assign out_link       = r_link;
  assign out_misaligned = r_misaligned;
  assign out_illegal    = r_illegal;

  assign w_unused_pred = ^pred_pc;

`ifdef BRANCH_BHT_EN
  localparam int unsigned BHT_IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

  logic [1:0]           r_bht [BHT_ENTRIES];
  logic [BHT_IDX_W-1:0] r_bht_idx;
  logic                 r_bht_upd;
  logic                 w_bht_we;
  logic [BHT_IDX_W-1:0] w_pred_idx;

  // Training context travels with the result so the update uses the resolved PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bht_idx <= '0;
      r_bht_upd <= 1'b0;
    end else if (w_accept) begin
      r_bht_idx <= in_pc[BHT_IDX_W+1:2];
      r_bht_upd <= w_sel_br && !w_illegal;
    end
  end

  assign w_bht_we = r_valid && out_ready && r_bht_upd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (w_bht_we) begin
      if (r_taken && (r_bht[r_bht_idx] != 2'b11)) begin
        r_bht[r_bht_idx] <= r_bht[r_bht_idx] + 2'd1;
      end else if (!r_taken && (r_bht[r_bht_idx] != 2'b00)) begin
        r_bht[r_bht_idx] <= r_bht[r_bht_idx] - 2'd1;
      end
    end
  end

  assign w_pred_idx = pred_pc[BHT_IDX_W+1:2];
  assign pred_taken = r_bht[w_pred_idx][1];
`else
  assign pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed vectors, queue of expected results, negedge monitor.
module tb_branch_resolve_unit;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [31:0] link;
    logic        mis;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic        in_is_branch, in_is_jal, in_is_jalr;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
  logic        out_valid, out_ready, out_taken, out_misaligned, out_illegal;
  logic [31:0] out_target, out_link;
  logic [31:0] pred_pc;
  logic        pred_taken;

  logic        in_ready16, out_valid16, out_taken16, out_mis16, out_ill16, pred_taken16;
  logic [31:0] out_target16, out_link16;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .IALIGN(32), .BHT_ENTRIES(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_is_branch(in_is_branch), .in_is_jal(in_is_jal),
    .in_is_jalr(in_is_jalr), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_target(out_target), .out_link(out_link),
    .out_misaligned(out_misaligned), .out_illegal(out_illegal),
    .pred_pc(pred_pc), .pred_taken(pred_taken)
  );

  branch_resolve_unit #(.XLEN(32), .IALIGN(16), .BHT_ENTRIES(64)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .in_funct3(in_funct3), .in_is_branch(in_is_branch), .in_is_jal(in_is_jal),
    .in_is_jalr(in_is_jalr), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .out_valid(out_valid16), .out_ready(1'b1),
    .out_taken(out_taken16), .out_target(out_target16), .out_link(out_link16),
    .out_misaligned(out_mis16), .out_illegal(out_ill16),
    .pred_pc(pred_pc), .pred_taken(pred_taken16)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: every result handshake pops and compares the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got target 0x%08h expected no result", out_target);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("taken",      32'(out_taken),      32'(e.taken));
          chk("target",     out_target,          e.target);
          chk("link",       out_link,            e.link);
          chk("misaligned", 32'(out_misaligned), 32'(e.mis));
          chk("illegal",    32'(out_illegal),    32'(e.ill));
        end
      end
    end
  end

  // Drive one request, push its expectation when it is accepted.
  task automatic send(input logic [2:0] f3, input logic br, input logic jal, input logic jalr,
                      input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] imm, input exp_t e);
    bit done = 0;
    in_funct3 = f3; in_is_branch = br; in_is_jal = jal; in_is_jalr = jalr;
    in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        done = 1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    #1;
  endtask

  function automatic exp_t mk(input logic tk, input logic [31:0] tg, input logic [31:0] lk,
                              input logic mis, input logic ill);
    mk = '{taken: tk, target: tg, link: lk, mis: mis, ill: ill};
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; pred_pc = 32'h40;
    in_funct3 = '0; in_is_branch = 0; in_is_jal = 0; in_is_jalr = 0;
    in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid",  32'(out_valid), 32'd0);
    chk("rst_out_target", out_target,     32'd0);
    chk("rst_out_link",   out_link,       32'd0);
    chk("rst_in_ready",   32'(in_ready),  32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Compare coverage, back-to-back at full rate.
    send(3'b100, 1, 0, 0, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, mk(1, 32'h120, 32'h104, 0, 0));
    send(3'b110, 1, 0, 0, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, mk(0, 32'h120, 32'h104, 0, 0));
    send(3'b101, 1, 0, 0, 32'h200, 32'h8000_0000, 32'h7FFF_FFFF, 32'h10, mk(0, 32'h210, 32'h204, 0, 0));
    send(3'b111, 1, 0, 0, 32'h200, 32'h8000_0000, 32'h7FFF_FFFF, 32'h10, mk(1, 32'h210, 32'h204, 0, 0));
    send(3'b000, 1, 0, 0, 32'h300, 32'h5, 32'h5, 32'hFFFF_FFF8, mk(1, 32'h2F8, 32'h304, 0, 0));
    send(3'b001, 1, 0, 0, 32'h300, 32'h5, 32'h5, 32'hFFFF_FFF8, mk(0, 32'h2F8, 32'h304, 0, 0));
    drain();

    // JALR with odd sum: bit0 cleared, still misaligned at 32-bit alignment only.
    send(3'b000, 0, 0, 1, 32'h400, 32'h1001, 32'h0, 32'h2, mk(1, 32'h1002, 32'h404, 1, 0));
    chk("ialign16_target",     out_target16,       32'h1002);
    chk("ialign16_misaligned", 32'(out_mis16),     32'd0);
    chk("ialign16_taken",      32'(out_taken16),   32'd1);
    send(3'b010, 0, 1, 1, 32'h500, 32'h2000, 32'h0, 32'h100, mk(1, 32'h2100, 32'h504, 0, 0));
    send(3'b111, 0, 1, 0, 32'h500, 32'h2000, 32'h0, 32'h100, mk(1, 32'h600, 32'h504, 0, 0));
    send(3'b010, 1, 0, 0, 32'h600, 32'h7, 32'h7, 32'h4, mk(0, 32'h604, 32'h604, 0, 1));
    send(3'b011, 1, 0, 0, 32'h600, 32'h7, 32'h8, 32'h4, mk(0, 32'h604, 32'h604, 0, 1));
    send(3'b000, 1, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h8, mk(1, 32'h4, 32'h0, 0, 0));
    send(3'b000, 0, 0, 0, 32'h700, 32'h1, 32'h1, 32'h10, mk(0, 32'h710, 32'h704, 0, 0));
    send(3'b000, 1, 0, 0, 32'h100, 32'h3, 32'h3, 32'h6, mk(1, 32'h106, 32'h104, 1, 0));
    drain();

    // Backpressure: three requests while the consumer stalls for two cycles.
    out_ready = 1'b0;
    fork
      begin
        send(3'b001, 1, 0, 0, 32'h800, 32'h1, 32'h2, 32'h40, mk(1, 32'h840, 32'h804, 0, 0));
        send(3'b110, 1, 0, 0, 32'h900, 32'h1, 32'h2, 32'h80, mk(1, 32'h980, 32'h904, 0, 0));
        send(3'b101, 1, 0, 0, 32'hA00, 32'h1, 32'h2, 32'hFFFF_FFFC, mk(0, 32'h9FC, 32'hA04, 0, 0));
      end
      begin
        bit seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
          @(negedge clk);
          seen = out_valid;
        end
        chk("stall_out_valid", 32'(seen), 32'd1);
        for (int c = 0; c < 2; c++) begin
          if (c != 0) @(negedge clk);
          chk("stall_in_ready",  32'(in_ready),  32'd0);
          chk("stall_held_target", out_target,   32'h840);
          chk("stall_held_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset during a stall discards the pending result at once.
    out_ready = 1'b0;
    send(3'b000, 1, 0, 0, 32'hB00, 32'h9, 32'h9, 32'h8, mk(1, 32'hB08, 32'hB04, 0, 0));
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midstall_reset_valid",  32'(out_valid),  32'd0);
    chk("midstall_reset_taken",  32'(out_taken),  32'd0);
    chk("midstall_reset_target", out_target,      32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

`ifdef BRANCH_BHT_EN
    // Predictor training at pc 0x40: 01 -> 10 -> 11 -> 11 -> 10 -> 01, JAL leaves it.
    chk("bht_init", 32'(pred_taken), 32'd0);
    for (int k = 0; k < 3; k++) begin
      send(3'b000, 1, 0, 0, 32'h40, 32'h1, 32'h1, 32'h10, mk(1, 32'h50, 32'h44, 0, 0));
      drain();
      @(posedge clk); #1;
      chk("bht_after_taken", 32'(pred_taken), 32'd1);
    end
    send(3'b000, 1, 0, 0, 32'h40, 32'h1, 32'h2, 32'h10, mk(0, 32'h50, 32'h44, 0, 0));
    drain();
    @(posedge clk); #1;
    chk("bht_nt1", 32'(pred_taken), 32'd1);
    send(3'b000, 1, 0, 0, 32'h40, 32'h1, 32'h2, 32'h10, mk(0, 32'h50, 32'h44, 0, 0));
    drain();
    @(posedge clk); #1;
    chk("bht_nt2", 32'(pred_taken), 32'd0);
    send(3'b000, 1, 0, 0, 32'h40, 32'h1, 32'h1, 32'h10, mk(1, 32'h50, 32'h44, 0, 0));
    drain();
    @(posedge clk); #1;
    chk("bht_retrain", 32'(pred_taken), 32'd1);
    send(3'b000, 1, 0, 0, 32'h40, 32'h1, 32'h2, 32'h10, mk(0, 32'h50, 32'h44, 0, 0));
    drain();
    @(posedge clk); #1;
    chk("bht_back_to_01", 32'(pred_taken), 32'd0);
    send(3'b000, 0, 1, 0, 32'h40, 32'h0, 32'h0, 32'h8, mk(1, 32'h48, 32'h44, 0, 0));
    drain();
    @(posedge clk); #1;
    chk("bht_jal_no_update", 32'(pred_taken), 32'd0);
`else
    chk("pred_tied_low", 32'(pred_taken), 32'd0);
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
